// File: rtl/pulse_arbiter.sv
// pulse_arbiter: two requesters (A, B) share one max-and-pulse datapath.
// The granted pair's unsigned max sets how many cycles `out` stays high;
// the winner's rfd/dav handshake is then completed before the next grant.
// Optional build macro PULSE_ARB_FIXED_PRIO_EN: A always wins ties
// (PRIO held at 0); default is round-robin between A and B.
module pulse_arbiter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         dav_a,
    input  logic [W-1:0] xa,
    input  logic [W-1:0] ya,
    output logic         rfd_a,
    input  logic         dav_b,
    input  logic [W-1:0] xb,
    input  logic [W-1:0] yb,
    output logic         rfd_b,
    output logic         out,
    output logic         gnt_a,
    output logic         gnt_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           prio_q, prio_d;
    logic           win_q, win_d;

    logic [W-1:0]   max_a, max_b, max_sel;
    logic           any_dav, winner, winner_dav;

    // Per-requester unsigned maximum of its operand pair
    always_comb begin
        max_a = (xa >= ya) ? xa : ya;
        max_b = (xb >= yb) ? xb : yb;
    end

    // Arbitration: a lone requester wins, a tie goes to the PRIO favourite
    always_comb begin
        any_dav = dav_a | dav_b;
        if (dav_a && dav_b) begin
            winner = prio_q;
        end else begin
            winner = dav_b;
        end
        max_sel    = winner ? max_b : max_a;
        winner_dav = win_q ? dav_b : dav_a;
    end

    // Next-state and register updates for the transaction FSM
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prio_d  = prio_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (any_dav) begin
                    win_d   = winner;
                    count_d = max_sel;
`ifdef PULSE_ARB_FIXED_PRIO_EN
                    prio_d  = 1'b0;
`else
                    prio_d  = ~winner;
`endif
                    state_d = (max_sel != '0) ? PULSE : DRAIN;
                end
            end
            PULSE: begin
                count_d = count_q - W'(1);
                // COUNT is never zero here; <= keeps the FSM safe regardless
                if (count_q <= W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!winner_dav) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                prio_d  = 1'b0;
                win_d   = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            count_q <= '0;
            prio_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prio_q  <= prio_d;
            win_q   <= win_d;
        end
    end

    // Output decode purely from registered state, so reset clears it at once
    always_comb begin
        rfd_a = 1'b0;
        rfd_b = 1'b0;
        out   = 1'b0;
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        case (state_q)
            IDLE: begin
                rfd_a = 1'b1;
                rfd_b = 1'b1;
            end
            PULSE: begin
                out   = 1'b1;
                gnt_a = ~win_q;
                gnt_b = win_q;
            end
            DRAIN: begin
                gnt_a = ~win_q;
                gnt_b = win_q;
            end
            default: begin
                rfd_a = 1'b1;
                rfd_b = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_arbiter.sv
// Self-checking bench for pulse_arbiter: directed tasks plus a scoreboard
// that pairs each observed transaction (winner, pulse length) with the
// entry pushed when the stimulus was driven.
module tb_pulse_arbiter;

    localparam int W = 8;

    logic         clock;
    logic         reset_;
    logic         dav_a, dav_b;
    logic [W-1:0] xa, ya, xb, yb;
    logic         rfd_a, rfd_b, out, gnt_a, gnt_b;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic win;
        int   len;
    } exp_t;

    exp_t exp_q[$];

    pulse_arbiter #(.W(W)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .dav_a  (dav_a),
        .xa     (xa),
        .ya     (ya),
        .rfd_a  (rfd_a),
        .dav_b  (dav_b),
        .xb     (xb),
        .yb     (yb),
        .rfd_b  (rfd_b),
        .out    (out),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end

    // Scoreboard monitor: sample on the falling edge, measure each granted
    // transaction and compare it with the oldest expected entry.
    logic mon_active = 1'b0;
    logic mon_win    = 1'b0;
    int   mon_len    = 0;

    always @(negedge clock) begin
        if (!reset_) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && (gnt_a || gnt_b)) begin
                mon_active = 1'b1;
                mon_win    = gnt_b;
                mon_len    = 0;
            end
            if (mon_active) begin
                if (gnt_a || gnt_b) begin
                    n_cmp++;
                    if ((gnt_a && gnt_b) || (gnt_b !== mon_win)) begin
                        n_err++;
                        $display("FAIL sb_grant_onehot: gnt_a=%b gnt_b=%b, required one-hot winner %0d",
                                 gnt_a, gnt_b, mon_win);
                    end
                    if (out) mon_len++;
                end else begin
                    mon_active = 1'b0;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected: transaction win=%0d len=%0d with empty scoreboard",
                                 mon_win, mon_len);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (mon_win !== e.win || mon_len != e.len) begin
                            n_err++;
                            $display("FAIL sb_txn: got win=%0d len=%0d, required win=%0d len=%0d",
                                     mon_win, mon_len, e.win, e.len);
                        end
                    end
                end
            end else begin
                n_cmp++;
                if (out !== 1'b0) begin
                    n_err++;
                    $display("FAIL sb_out_no_grant: out=%b without grant, required 0", out);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive the handshake until both requesters are idle: a winner drops dav in DRAIN
    task automatic run_until_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (gnt_a && !out) dav_a = 1'b0;
            if (gnt_b && !out) dav_b = 1'b0;
            if (rfd_a && rfd_b && !dav_a && !dav_b && !gnt_a && !gnt_b) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        dav_a = 1'b0; dav_b = 1'b0;
        xa = '0; ya = '0; xb = '0; yb = '0;
        repeat (3) step();
        n_cmp++;
        if (rfd_a !== 1'b1 || rfd_b !== 1'b1 || out !== 1'b0 || gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: rfd_a=%b rfd_b=%b out=%b gnt_a=%b gnt_b=%b, required 1 1 0 0 0",
                     rfd_a, rfd_b, out, gnt_a, gnt_b);
        end
        n_cmp++;
        if (dut.count_q !== 8'd0) begin
            n_err++;
            $display("FAIL reset_count: count=%0d, required 0", dut.count_q);
        end
        reset_ = 1'b1;
        step();
    endtask

    task automatic test_single();
        dav_a = 1'b1; xa = 8'd5; ya = 8'd3;
        exp_q.push_back('{1'b0, 5});
        step();
        n_cmp++;
        if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || rfd_a !== 1'b0 || rfd_b !== 1'b0 || out !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: gnt_a=%b gnt_b=%b rfd_a=%b rfd_b=%b out=%b, required 1 0 0 0 1",
                     gnt_a, gnt_b, rfd_a, rfd_b, out);
        end
        for (int i = 1; i < 5; i++) begin
            step();
            n_cmp++;
            if (out !== 1'b1) begin
                n_err++;
                $display("FAIL single_pulse_cycle%0d: out=%b, required 1", i + 1, out);
            end
        end
        step();
        n_cmp++;
        if (out !== 1'b0 || rfd_a !== 1'b0 || gnt_a !== 1'b1) begin
            n_err++;
            $display("FAIL single_pulse_end: out=%b rfd_a=%b gnt_a=%b, required 0 0 1", out, rfd_a, gnt_a);
        end
        step();
        n_cmp++;
        if (rfd_a !== 1'b0) begin
            n_err++;
            $display("FAIL single_drain_hold: rfd_a=%b, required 0 while dav_a high", rfd_a);
        end
        dav_a = 1'b0;
        step();
        n_cmp++;
        if (rfd_a !== 1'b1 || gnt_a !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: rfd_a=%b gnt_a=%b, required 1 0", rfd_a, gnt_a);
        end
        step();
    endtask

    task automatic test_zero_length();
        dav_b = 1'b1; xb = 8'd0; yb = 8'd0;
        exp_q.push_back('{1'b1, 0});
        step();
        n_cmp++;
        if (gnt_b !== 1'b1 || gnt_a !== 1'b0 || out !== 1'b0 || rfd_b !== 1'b0) begin
            n_err++;
            $display("FAIL zero_drain: gnt_b=%b gnt_a=%b out=%b rfd_b=%b, required 1 0 0 0",
                     gnt_b, gnt_a, out, rfd_b);
        end
        dav_b = 1'b0;
        step();
        n_cmp++;
        if (rfd_b !== 1'b1 || gnt_b !== 1'b0) begin
            n_err++;
            $display("FAIL zero_release: rfd_b=%b gnt_b=%b, required 1 0", rfd_b, gnt_b);
        end
        step();
    endtask

    task automatic test_round_robin();
        int g;
        bit in_txn, want_a, want_b, done;
        g = 0; in_txn = 1'b0; want_a = 1'b1; want_b = 1'b1; done = 1'b0;
`ifdef PULSE_ARB_FIXED_PRIO_EN
        exp_q.push_back('{1'b0, 4});
        exp_q.push_back('{1'b0, 4});
        exp_q.push_back('{1'b0, 4});
        exp_q.push_back('{1'b1, 7});
`else
        exp_q.push_back('{1'b0, 4});
        exp_q.push_back('{1'b1, 7});
        exp_q.push_back('{1'b0, 4});
        exp_q.push_back('{1'b1, 7});
`endif
        xa = 8'd2; ya = 8'd4; xb = 8'd7; yb = 8'd1;
        dav_a = 1'b1; dav_b = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if ((gnt_a || gnt_b) && !in_txn) begin
                in_txn = 1'b1;
                g++;
            end
            if (gnt_a && !out) begin
                dav_a = 1'b0;
                if (g >= 3) want_a = 1'b0;
            end
            if (gnt_b && !out) begin
                dav_b = 1'b0;
                if (g >= 3) want_b = 1'b0;
            end
            if (!gnt_a && !gnt_b) begin
                in_txn = 1'b0;
                if (want_a) dav_a = 1'b1;
                if (want_b) dav_b = 1'b1;
            end
            if (g == 4 && !in_txn && !dav_a && !dav_b) done = 1'b1;
        end
        n_cmp++;
        if (!done || g != 4) begin
            n_err++;
            $display("FAIL rr_completion: done=%0d grants=%0d, required 1 and 4", done, g);
        end
        step();
    endtask

    task automatic test_full_width();
        int len;
        dav_a = 1'b1; xa = 8'd255; ya = 8'd10;
        exp_q.push_back('{1'b0, 255});
        step();
        // operands change after the grant edge and must be ignored
        xa = 8'd1; ya = 8'd1;
        len = 0;
        for (int i = 0; i < 300 && out; i++) begin
            len++;
            step();
        end
        n_cmp++;
        if (len != 255) begin
            n_err++;
            $display("FAIL full_len: pulse=%0d cycles, required 255", len);
        end
        n_cmp++;
        if (dut.count_q !== 8'd0 || gnt_a !== 1'b1) begin
            n_err++;
            $display("FAIL full_count: count=%0d gnt_a=%b, required 0 1", dut.count_q, gnt_a);
        end
        dav_a = 1'b0;
        step();
        n_cmp++;
        if (rfd_a !== 1'b1 || rfd_b !== 1'b1) begin
            n_err++;
            $display("FAIL full_release: rfd_a=%b rfd_b=%b, required 1 1", rfd_a, rfd_b);
        end
        step();
    endtask

    task automatic test_reset_mid_pulse();
        bit ok;
        dav_a = 1'b1; xa = 8'd9; ya = 8'd0;
        step();
        step();
        step();
        n_cmp++;
        if (out !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre_pulse: out=%b, required 1 at pulse cycle 3", out);
        end
        #2;
        reset_ = 1'b0;
        #1;
        n_cmp++;
        if (out !== 1'b0 || rfd_a !== 1'b1 || rfd_b !== 1'b1 || gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
            n_err++;
            $display("FAIL rst_async: out=%b rfd_a=%b rfd_b=%b gnt_a=%b gnt_b=%b, required 0 1 1 0 0",
                     out, rfd_a, rfd_b, gnt_a, gnt_b);
        end
        dav_a = 1'b0;
        repeat (2) step();
        reset_ = 1'b1;
        step();
        n_cmp++;
        if (out !== 1'b0 || gnt_a !== 1'b0 || rfd_a !== 1'b1) begin
            n_err++;
            $display("FAIL rst_no_resume: out=%b gnt_a=%b rfd_a=%b, required 0 0 1", out, gnt_a, rfd_a);
        end
        xa = 8'd2; ya = 8'd0; xb = 8'd1; yb = 8'd2;
        dav_a = 1'b1; dav_b = 1'b1;
        exp_q.push_back('{1'b0, 2});
        exp_q.push_back('{1'b1, 2});
        step();
        n_cmp++;
        if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
            n_err++;
            $display("FAIL rst_prio_tie: gnt_a=%b gnt_b=%b, required 1 0", gnt_a, gnt_b);
        end
        run_until_idle(60, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL rst_after_idle: timeout waiting for idle, required idle within 60 cycles");
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_length();
        test_round_robin();
        test_full_width();
        test_reset_mid_pulse();
        repeat (5) step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d expected transactions unseen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
